// File: rtl/matmul_engine.sv
// matmul_engine: computes RES = (A x B) >> 8 (truncated to WIDTH bits) by
// streaming A_RAM and B_RAM through a single multiply-accumulate lane.
// One RES element takes A_COLS read cycles, one drain cycle and one write cycle.
module matmul_engine #(
    parameter int WIDTH          = 8,
    parameter int A_ROWS         = 2,
    parameter int A_COLS         = 4,
    parameter int B_COLS         = 1,
    parameter int A_DEPTH_BITS   = 3,
    parameter int B_DEPTH_BITS   = 2,
    parameter int RES_DEPTH_BITS = 1
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      Start,
    output logic                      Done,
    output logic                      Busy,
    output logic                      A_read_en,
    output logic [A_DEPTH_BITS-1:0]   A_read_address,
    input  logic [WIDTH-1:0]          A_read_data_out,
    output logic                      B_read_en,
    output logic [B_DEPTH_BITS-1:0]   B_read_address,
    input  logic [WIDTH-1:0]          B_read_data_out,
    output logic                      RES_write_en,
    output logic [RES_DEPTH_BITS-1:0] RES_write_address,
    output logic [WIDTH-1:0]          RES_write_data_in
);

    localparam int ACC_W  = 2*WIDTH + $clog2(A_COLS);
    localparam int PROD_W = 2*WIDTH;
    localparam int R_W    = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
    localparam int C_W    = (B_COLS > 1) ? $clog2(B_COLS) : 1;
    localparam int K_W    = (A_COLS > 1) ? $clog2(A_COLS) : 1;

    localparam logic [R_W-1:0] R_LAST = R_W'(A_ROWS - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(B_COLS - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(A_COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                    state_q, state_n;
    logic [R_W-1:0]            r_q, r_n;
    logic [C_W-1:0]            c_q, c_n;
    logic [K_W-1:0]            k_q, k_n;
    logic [ACC_W-1:0]          acc_q, acc_n;
    logic                      valid_q;
    logic [PROD_W-1:0]         prod;
    logic [A_DEPTH_BITS-1:0]   a_addr_n;
    logic [B_DEPTH_BITS-1:0]   b_addr_n;
    logic [RES_DEPTH_BITS-1:0] res_addr_n;

    // State, counters and accumulator register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            r_q     <= r_n;
            c_q     <= c_n;
            k_q     <= k_n;
            acc_q   <= acc_n;
            // read data arrives one cycle after the enable that requested it
            valid_q <= A_read_en;
        end
    end

    // Next-state, counter advance, accumulation and next-cycle addresses.
    always_comb begin
        state_n = state_q;
        r_n     = r_q;
        c_n     = c_q;
        k_n     = k_q;
        acc_n   = acc_q;
        prod    = PROD_W'(A_read_data_out) * PROD_W'(B_read_data_out);

        if (valid_q) begin
            acc_n = acc_q + ACC_W'(prod);
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_n = RUN;
                    r_n     = '0;
                    c_n     = '0;
                    k_n     = '0;
                    acc_n   = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_n = DRAIN;
                end else begin
                    k_n = k_q + K_W'(1);
                end
            end
            DRAIN: begin
                state_n = WRITE;
            end
            WRITE: begin
                acc_n = '0;
                k_n   = '0;
                if (c_q == C_LAST) begin
                    c_n = '0;
                    if (r_q == R_LAST) begin
                        state_n = DONE;
                    end else begin
                        r_n     = r_q + R_W'(1);
                        state_n = RUN;
                    end
                end else begin
                    c_n     = c_q + C_W'(1);
                    state_n = RUN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        a_addr_n   = A_DEPTH_BITS'(32'(r_n) * 32'(A_COLS) + 32'(k_n));
        b_addr_n   = B_DEPTH_BITS'(32'(k_n) * 32'(B_COLS) + 32'(c_n));
        res_addr_n = RES_DEPTH_BITS'(32'(r_n) * 32'(B_COLS) + 32'(c_n));
    end

    // Registered outputs: loaded from the next state so they line up with the
    // state they belong to (write data therefore takes the final accumulation).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            Done              <= 1'b0;
            Busy              <= 1'b0;
            A_read_en         <= 1'b0;
            A_read_address    <= '0;
            B_read_en         <= 1'b0;
            B_read_address    <= '0;
            RES_write_en      <= 1'b0;
            RES_write_address <= '0;
            RES_write_data_in <= '0;
        end else begin
            Done         <= (state_n == DONE);
            Busy         <= (state_n != IDLE);
            A_read_en    <= (state_n == RUN);
            B_read_en    <= (state_n == RUN);
            RES_write_en <= (state_n == WRITE);
            if (state_n == RUN) begin
                A_read_address <= a_addr_n;
                B_read_address <= b_addr_n;
            end
            if (state_n == WRITE) begin
                RES_write_address <= res_addr_n;
                RES_write_data_in <= acc_n[WIDTH+7:8];
            end
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: drives matmul_engine against behavioural A/B/RES RAMs and
// checks results, cycle schedule, Start handling and mid-run reset.
module tb_matmul_engine;

    logic       ACLK = 1'b0;
    logic       ARESETN;
    logic       Start;
    logic       Done, Busy;
    logic       A_read_en, B_read_en, RES_write_en;
    logic [2:0] A_read_address;
    logic [1:0] B_read_address;
    logic [0:0] RES_write_address;
    logic [7:0] A_read_data_out, B_read_data_out, RES_write_data_in;

    logic [7:0] a_mem [8];
    logic [7:0] b_mem [4];
    logic [7:0] res_mem [2] = '{8'hEE, 8'hEE};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ACLK = ~ACLK;

    matmul_engine #(
        .WIDTH(8), .A_ROWS(2), .A_COLS(4), .B_COLS(1),
        .A_DEPTH_BITS(3), .B_DEPTH_BITS(2), .RES_DEPTH_BITS(1)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .Start(Start), .Done(Done), .Busy(Busy),
        .A_read_en(A_read_en), .A_read_address(A_read_address),
        .A_read_data_out(A_read_data_out),
        .B_read_en(B_read_en), .B_read_address(B_read_address),
        .B_read_data_out(B_read_data_out),
        .RES_write_en(RES_write_en), .RES_write_address(RES_write_address),
        .RES_write_data_in(RES_write_data_in)
    );

    // Synchronous RAM models around the engine.
    always @(posedge ACLK) begin
        if (A_read_en)    A_read_data_out <= a_mem[A_read_address];
        if (B_read_en)    B_read_data_out <= b_mem[B_read_address];
        if (RES_write_en) res_mem[RES_write_address] <= RES_write_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Dot product of row r of A with column c of B, divided by 256, low 8 bits kept.
    function automatic logic [7:0] ref_res(input int r, input int c);
        int unsigned sum = 0;
        for (int k = 0; k < 4; k++) sum += a_mem[r*4 + k] * b_mem[k*1 + c];
        return 8'((sum / 256) % 256);
    endfunction

    function automatic logic [31:0] raw_out();
        return {13'd0, A_read_en, B_read_en, RES_write_en, Done, Busy,
                A_read_address, B_read_address, RES_write_address, RES_write_data_in};
    endfunction

    function automatic logic [31:0] got_sched();
        return {20'd0, A_read_en, B_read_en,
                A_read_en ? A_read_address : 3'd0,
                B_read_en ? B_read_address : 2'd0,
                RES_write_en, RES_write_en ? RES_write_address : 1'b0, Done, Busy};
    endfunction

    // Expected outputs in cycle i after the accepting edge: each element is
    // 4 read cycles, a drain cycle and a write cycle; Done follows the last write.
    function automatic logic [31:0] exp_sched(input int i);
        int  e = (i - 1) / 6;
        int  p = (i - 1) % 6;
        bit  in_run = (i >= 1) && (i <= 12);
        bit  rd = in_run && (p < 4);
        bit  wr = in_run && (p == 5);
        logic [2:0] aa = rd ? 3'(e*4 + p) : 3'd0;
        logic [1:0] ba = rd ? 2'(p) : 2'd0;
        logic       wa = wr ? 1'(e) : 1'b0;
        return {20'd0, rd, rd, aa, ba, wr, wa, (i == 13), (i <= 13)};
    endfunction

    task automatic run_job(input int pulse_cyc, input int rst_cyc, input bit hold, input string tag);
        logic [7:0] exp0, exp1, old1;
        int done_cnt, wr_cnt, first_done;
        exp0 = ref_res(0, 0);
        exp1 = ref_res(1, 0);
        old1 = res_mem[1];
        done_cnt = 0; wr_cnt = 0; first_done = -1;
        @(negedge ACLK);
        Start = 1'b1;
        @(posedge ACLK);
        #1;
        if (!hold) Start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge ACLK);
            Start = hold ? (i <= 14) : (i == pulse_cyc);
            if (rst_cyc != 0 && i == rst_cyc) begin
                ARESETN = 1'b0;
                #1;
                check({tag, "_rst_outputs"}, raw_out(), 32'd0);
            end
            if (rst_cyc != 0 && i == rst_cyc + 1) ARESETN = 1'b1;
            if (Done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
            if (RES_write_en) wr_cnt++;
            if (rst_cyc == 0 && !hold) check({tag, "_sched"}, got_sched(), exp_sched(i));
            if (hold && i == 14) check({tag, "_busy_gap"}, 32'(Busy), 32'd0);
            if (hold && i == 15) check({tag, "_busy_restart"}, 32'(Busy), 32'd1);
        end
        if (rst_cyc == 0) begin
            check({tag, "_done_cnt"}, done_cnt, hold ? 2 : 1);
            check({tag, "_done_cyc"}, first_done, 13);
            check({tag, "_wr_cnt"}, wr_cnt, hold ? 4 : 2);
            check({tag, "_res0"}, res_mem[0], exp0);
            check({tag, "_res1"}, res_mem[1], exp1);
        end else begin
            check({tag, "_done_cnt"}, done_cnt, 0);
            check({tag, "_wr_cnt"}, wr_cnt, 1);
            check({tag, "_res0"}, res_mem[0], exp0);
            check({tag, "_res1_kept"}, res_mem[1], old1);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        Start   = 1'b0;
        repeat (3) @(negedge ACLK);
        check("reset_outputs", raw_out(), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        // 0x10/0x20 rows against 0x10 column
        for (int k = 0; k < 4; k++) begin
            a_mem[k] = 8'h10; a_mem[4 + k] = 8'h20; b_mem[k] = 8'h10;
        end
        run_job(0, 0, 1'b0, "basic");
        check("basic_res0_lit", res_mem[0], 32'h04);
        check("basic_res1_lit", res_mem[1], 32'h08);

        // all 0xFF, aborted by reset after RES[0] is written
        for (int k = 0; k < 8; k++) a_mem[k] = 8'hFF;
        for (int k = 0; k < 4; k++) b_mem[k] = 8'hFF;
        run_job(0, 9, 1'b0, "midrst");
        run_job(0, 0, 1'b0, "allff");
        check("allff_res0_lit", res_mem[0], 32'hF8);
        check("allff_res1_lit", res_mem[1], 32'hF8);

        // small sums vanish below the scaling point
        for (int k = 0; k < 8; k++) a_mem[k] = 8'(k + 1);
        for (int k = 0; k < 4; k++) b_mem[k] = 8'd1;
        run_job(0, 0, 1'b0, "small");
        check("small_res0_lit", res_mem[0], 32'h00);
        check("small_res1_lit", res_mem[1], 32'h00);

        // Start re-pulsed while busy, then Start held across DONE
        for (int k = 0; k < 8; k++) a_mem[k] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 4; k++) b_mem[k] = 8'($urandom_range(0, 255));
        run_job(5, 0, 1'b0, "repulse");
        run_job(0, 0, 1'b1, "hold");

        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 8; k++) a_mem[k] = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) b_mem[k] = 8'($urandom_range(0, 255));
            run_job(0, 0, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
